// File: rtl/axis_packet_aggregator_pkg.sv
// Shared types and helpers for the AXI4-Stream packet aggregator.
package axis_packet_aggregator_pkg;

    typedef enum logic [1:0] {
        UNSYNC    = 2'd0,
        SYNC_IDLE = 2'd1,
        SYNC_RUN  = 2'd2
    } agg_state_e;

    // Group size limited to 1..max_n; zero is treated as one.
    function automatic int unsigned clamp_n(input int unsigned cfg, input int unsigned max_n);
        if (cfg == 0) begin
            return 1;
        end else if (cfg > max_n) begin
            return max_n;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered input ready; full rate under backpressure.
module axis_skid_buffer #(
    parameter int unsigned DATA_WIDTH = 34
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  rdy_q, rdy_d;
    logic                  in_hs_c;

    assign in_ready  = rdy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= rdy_d;
        end
    end

    // Skid entry only fills when the output register is stalled.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        in_hs_c      = in_valid & rdy_q;

        if (!skid_valid_q) begin
            if (in_hs_c) begin
                if (!out_valid_q || out_ready) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                end else begin
                    skid_data_d  = in_data;
                    skid_valid_d = 1'b1;
                end
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end else if (out_ready) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end

        rdy_d = !skid_valid_d;
    end

endmodule

// File: rtl/axis_packet_aggregator.sv
// Merges N consecutive AXI4-Stream packets into one, aligning to a TLAST
// boundary after reset/resync; output is registered through a skid buffer.
module axis_packet_aggregator
    import axis_packet_aggregator_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH       = 32,
    parameter int unsigned MAX_PACKETS_PER_PACKET = 16,
    parameter int unsigned DISCARD_FIRST_PACKET   = 1,
    parameter int unsigned CNT_WIDTH              = $clog2(MAX_PACKETS_PER_PACKET + 1),
    parameter int unsigned STAT_WIDTH             = 32
) (
    input  logic                        axis_aclk,
    input  logic                        axis_areset,
    input  logic [CNT_WIDTH-1:0]        cfg_packets_per_packet,
    input  logic                        cfg_resync,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic                        stat_synced,
    output logic [STAT_WIDTH-1:0]       stat_dropped_beats,
    output logic [STAT_WIDTH-1:0]       stat_groups
);

    localparam int unsigned SKID_WIDTH = AXIS_TDATA_WIDTH + 2;
    localparam agg_state_e  RESET_STATE = (DISCARD_FIRST_PACKET != 0) ? UNSYNC : SYNC_IDLE;

    agg_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  n_lat_q, n_lat_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic                  resync_pend_q, resync_pend_d;
    logic                  synced_q, synced_d;
    logic                  live_q;
    logic [STAT_WIDTH-1:0] dropped_q, dropped_d;
    logic [STAT_WIDTH-1:0] groups_q, groups_d;

    logic                  skid_rdy;
    logic                  s_rdy_c;
    logic                  s_hs_c;
    logic                  fwd_valid_c;
    logic                  fwd_last_c;
    logic                  fwd_user_c;
    logic [CNT_WIDTH-1:0]  n_new_c;

    // Ready is a decode of registered state only; held low through reset.
    assign s_rdy_c = live_q & ((state_q == UNSYNC)
                             | ((state_q == SYNC_RUN) & skid_rdy)
                             | ((state_q == SYNC_IDLE) & !resync_pend_q & skid_rdy));

    assign s_axis_tready      = s_rdy_c;
    assign stat_synced        = synced_q;
    assign stat_dropped_beats = dropped_q;
    assign stat_groups        = groups_q;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q       <= RESET_STATE;
            n_lat_q       <= CNT_WIDTH'(1);
            pkt_cnt_q     <= '0;
            resync_pend_q <= 1'b0;
            synced_q      <= (DISCARD_FIRST_PACKET == 0);
            live_q        <= 1'b0;
            dropped_q     <= '0;
            groups_q      <= '0;
        end else begin
            state_q       <= state_d;
            n_lat_q       <= n_lat_d;
            pkt_cnt_q     <= pkt_cnt_d;
            resync_pend_q <= resync_pend_d;
            synced_q      <= synced_d;
            live_q        <= 1'b1;
            dropped_q     <= dropped_d;
            groups_q      <= groups_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        n_lat_d       = n_lat_q;
        pkt_cnt_d     = pkt_cnt_q;
        resync_pend_d = resync_pend_q;
        dropped_d     = dropped_q;
        groups_d      = groups_q;
        fwd_valid_c   = 1'b0;
        fwd_last_c    = 1'b0;
        fwd_user_c    = 1'b0;
        s_hs_c        = s_axis_tvalid & s_rdy_c;
        n_new_c       = CNT_WIDTH'(clamp_n(32'(cfg_packets_per_packet), MAX_PACKETS_PER_PACKET));

        case (state_q)
            UNSYNC: begin
                if (s_hs_c) begin
                    if (dropped_q != {STAT_WIDTH{1'b1}}) begin
                        dropped_d = dropped_q + STAT_WIDTH'(1);
                    end
                    if (s_axis_tlast) begin
                        state_d = SYNC_IDLE;
                    end
                end
            end
            SYNC_IDLE: begin
                if (resync_pend_q) begin
                    state_d       = UNSYNC;
                    resync_pend_d = 1'b0;
                end else if (s_hs_c) begin
                    fwd_valid_c = 1'b1;
                    fwd_user_c  = 1'b1;
                    n_lat_d     = n_new_c;
                    pkt_cnt_d   = '0;
                    state_d     = SYNC_RUN;
                    if (s_axis_tlast) begin
                        if (n_new_c == CNT_WIDTH'(1)) begin
                            fwd_last_c = 1'b1;
                            groups_d   = groups_q + STAT_WIDTH'(1);
                            state_d    = SYNC_IDLE;
                        end else begin
                            pkt_cnt_d = CNT_WIDTH'(1);
                        end
                    end
                end
            end
            SYNC_RUN: begin
                if (s_hs_c) begin
                    fwd_valid_c = 1'b1;
                    if (s_axis_tlast) begin
                        if (pkt_cnt_q == n_lat_q - CNT_WIDTH'(1)) begin
                            fwd_last_c = 1'b1;
                            pkt_cnt_d  = '0;
                            groups_d   = groups_q + STAT_WIDTH'(1);
                            state_d    = SYNC_IDLE;
                        end else begin
                            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // A new request wins over the clear so a pulse is never lost.
        if (cfg_resync && (DISCARD_FIRST_PACKET != 0)) begin
            resync_pend_d = 1'b1;
        end

        synced_d = (state_d != UNSYNC);
    end

    axis_skid_buffer #(
        .DATA_WIDTH (SKID_WIDTH)
    ) u_skid (
        .axis_aclk   (axis_aclk),
        .axis_areset (axis_areset),
        .in_data     ({fwd_user_c, fwd_last_c, s_axis_tdata}),
        .in_valid    (fwd_valid_c),
        .in_ready    (skid_rdy),
        .out_data    ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
        .out_valid   (m_axis_tvalid),
        .out_ready   (m_axis_tready)
    );

endmodule

// File: doc/axis_packet_aggregator.md
Name: axis_packet_aggregator

Overview:
AXI4-Stream packet combiner with a runtime-programmable group size. It merges N consecutive input packets into one output packet. After reset or an explicit resync it discards beats until it is aligned to an input TLAST boundary. Output is registered through a skid buffer, so the block sustains full throughput under backpressure and also reports a group-start marker and status counters. It sits between an ADC/DSP sample stream and the DMA packetiser.

Parameters:
AXIS_TDATA_WIDTH, 32, data width in bits
MAX_PACKETS_PER_PACKET, 16, upper bound on N (must be ≥1)
DISCARD_FIRST_PACKET, 1, 1 = unsynced after reset/resync and drops until the first TLAST; 0 = synced from reset
CNT_WIDTH, $clog2(MAX_PACKETS_PER_PACKET+1), width of the N config and packet counter
STAT_WIDTH, 32, width of status counters

Ports:
axis_aclk  in  1  clock
axis_areset  in  1  reset, asynchronous, active-high
cfg_packets_per_packet  in  CNT_WIDTH  N, sampled at each group start
cfg_resync  in  1  single-cycle pulse that requests re-alignment
s_axis_tdata  in  AXIS_TDATA_WIDTH  input data
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input packet end
m_axis_tdata  out  AXIS_TDATA_WIDTH  output data
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  end of combined packet
m_axis_tuser  out  1  first beat of combined packet
stat_synced  out  1  aligned to input packet boundary
stat_dropped_beats  out  STAT_WIDTH  beats discarded while unsynced (saturating)
stat_groups  out  STAT_WIDTH  combined packets emitted (wrapping)

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, tdata=0, tlast=0, tuser=0; s_axis_tready=0 while in reset. stat_synced = !DISCARD_FIRST_PACKET. Counters=0, pkt_cnt=0, resync_pending=0.
- An input handshake occurs when s_tvalid & s_tready.
- State machine:
  - UNSYNC: s_tready=1, every beat is dropped and stat_dropped_beats increments. A TLAST handshake moves to SYNC_IDLE. If DISCARD_FIRST_PACKET=0, reset enters SYNC_IDLE directly.
  - SYNC_IDLE: group boundary. The first handshake latches n_lat = clamp(cfg, 1..MAX), where 0 maps to 1 and values above MAX map to MAX. That beat is forwarded with tuser=1, and the state moves to SYNC_RUN. If n_lat=1 and the beat has TLAST, the beat goes out with tlast=1 and the state stays SYNC_IDLE.
  - SYNC_RUN: beats are forwarded. Each input TLAST handshake increments pkt_cnt. On the TLAST where pkt_cnt==n_lat-1, the beat goes out with m_tlast=1, pkt_cnt returns to 0, stat_groups increments, and the state goes to SYNC_IDLE. Every other TLAST is forwarded with m_tlast=0.
- cfg_resync sets resync_pending. resync_pending is acted on only in SYNC_IDLE, so an in-flight group always completes intact.
  - In SYNC_IDLE with resync_pending=1: go to UNSYNC and clear resync_pending. No beat is accepted that cycle.
  - With DISCARD_FIRST_PACKET=0, resync is ignored.
- A cfg change mid-group has no effect until the next SYNC_IDLE.
- Forwarding goes through a 2-entry skid buffer:
  - Latency is 1 cycle from input handshake to m_tvalid.
  - s_tready in SYNC states equals skid-buffer ready, which is registered and not combinationally dependent on m_tready.
  - Full rate is 1 beat/cycle with m_tready=1.
  - m_axis_* stays stable while m_tvalid=1 and m_tready=0.
- Simultaneous events:
  - A TLAST and a resync pulse in the same cycle: the TLAST is processed normally, and resync takes effect at the next SYNC_IDLE.
  - A drop in UNSYNC does not require m_tready.
- Saturation and wrap: stat_dropped_beats saturates at all-ones. stat_groups wraps.
- Reset mid-group: the partial output is lost, the skid buffer is flushed (m_tvalid=0 immediately), and the state returns to the reset state.

Decomposition:
- Package axis_packet_aggregator_pkg:
  - state enum: UNSYNC, SYNC_IDLE, SYNC_RUN
  - function clamp_n(cfg, max)
- Sub-module axis_skid_buffer:
  - parameter DATA_WIDTH (=AXIS_TDATA_WIDTH+2 for tlast/tuser)
  - ports axis_aclk / axis_areset
  - 2-entry, registered ready

Test Plan:
1. N=2, DISCARD=1, 3-beat packets, gapped tvalid. Send 2,3L; 11,12,13L; 21,22,23L; 31,32,33L; 41,42,43L → 2,3 dropped (stat_dropped_beats=2). Output 11(tuser),12,13,21,22,23L and 31(tuser),32,33,41,42,43L. stat_groups=2.
2. Same stimulus at full speed with m_tready=1 → identical output. s_tready stays 1 throughout, no bubbles after the first output.
3. TLAST tied 1, N=2, data 0..9 → 0 dropped. Output (1,2L),(3,4L),(5,6L),(7,8L); 9 is held awaiting its pair. stat_synced=1 after beat 0.
4. Backpressure: as test 2 with m_tready toggling 1010… and with m_tready=0 for 5 cycles → no data loss or duplication, same sequence as test 1, outputs stable while stalled.
5. Runtime N and resync:
  - Set cfg=3 mid-group → the current group closes at old N=2, and the next group spans 3 packets.
  - cfg=0 → groups of 1.
  - Pulse cfg_resync mid-group → the group completes, the next input packet is dropped, and aggregation resumes.
6. Assert axis_areset during beat 12 of test 1 → m_tvalid=0 at once and counters cleared. After release, the next partial packet is dropped and the sequence resumes correctly.
